// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock ratio monitor: FSM state encoding, parameter defaults
// and the duty-cycle acceptance rule used when CLK_MON_DUTY_CHECK_EN is defined.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } monState_t;

    localparam int RATIO_WIDTH_DEF = 8;
    localparam int LOCK_COUNT_DEF  = 4;

    // An odd ratio cannot split evenly, so either rounding of half the period is accepted.
    function automatic logic dutyMatch(input int unsigned highTime, input int unsigned expRatio);
        return (highTime == (expRatio >> 1)) || (highTime == ((expRatio + 1) >> 1));
    endfunction

endpackage

// File: rtl/clk_mon_edge_det.sv
// Brings the asynchronous divided clock into the i_ref_clk domain through two flops
// and a third flop for edge detection; all edges see the same fixed latency.
module clk_mon_edge_det (
    input  logic i_ref_clk,
    input  logic i_rst_n,
    input  logic i_div_clk,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_div_clk;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/clk_ratio_mon.sv
// Clock ratio monitor: measures period and high time of i_div_clk in i_ref_clk cycles and tracks lock.
// Build macro CLK_MON_DUTY_CHECK_EN additionally requires the high time to be half the expected ratio.
module clk_ratio_mon
    import clk_mon_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_div_clk,
    input  logic [RATIO_WIDTH-1:0] i_exp_ratio,
    output logic [RATIO_WIDTH-1:0] o_meas_ratio,
    output logic [RATIO_WIDTH-1:0] o_high_time,
    output logic                   o_valid,
    output logic                   o_locked,
    output logic                   o_err,
    output logic                   o_stuck
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RATIO_WIDTH-1:0] CNT_MAX    = {RATIO_WIDTH{1'b1}};
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE    = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] MIN_RATIO  = RATIO_WIDTH'(2);
    localparam logic [MATCH_W-1:0]     MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0]     MATCH_FULL = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0]     MATCH_ONE  = MATCH_W'(1);

    monState_t              r_state;
    logic [MATCH_W-1:0]     r_matchCnt;
    logic [RATIO_WIDTH-1:0] r_periodCnt;
    logic [RATIO_WIDTH-1:0] r_highCnt;

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_saturated;
    logic w_ratioOk;
    logic w_dutyOk;
    logic w_match;

    clk_mon_edge_det u_edge_det (
        .i_ref_clk (i_ref_clk),
        .i_rst_n   (i_rst_n),
        .i_div_clk (i_div_clk),
        .o_level   (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_saturated = (r_periodCnt == CNT_MAX);
    assign w_ratioOk   = (i_exp_ratio >= MIN_RATIO);

`ifdef CLK_MON_DUTY_CHECK_EN
    assign w_dutyOk = dutyMatch(32'(r_highCnt), 32'(i_exp_ratio));
`else
    assign w_dutyOk = 1'b1;
`endif

    assign w_match = (r_periodCnt == i_exp_ratio) && w_dutyOk;

    // Both counters restart at 1 on the rise itself, so on the next rise they hold full cycle counts.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_periodCnt <= '0;
            r_highCnt   <= '0;
        end else if (w_rise) begin
            r_periodCnt <= CNT_ONE;
            r_highCnt   <= CNT_ONE;
        end else begin
            if (!w_saturated) begin
                r_periodCnt <= r_periodCnt + CNT_ONE;
            end
            if (w_level && !w_fall && (r_highCnt != CNT_MAX)) begin
                r_highCnt <= r_highCnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_matchCnt   <= '0;
            o_meas_ratio <= '0;
            o_high_time  <= '0;
            o_valid      <= 1'b0;
            o_locked     <= 1'b0;
            o_err        <= 1'b0;
            o_stuck      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (w_rise) begin
                o_stuck <= 1'b0;
            end
            if (!i_en || !w_ratioOk) begin
                r_state    <= ST_IDLE;
                r_matchCnt <= '0;
                o_locked   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (w_rise) begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        if (w_rise) begin
                            o_meas_ratio <= r_periodCnt;
                            o_high_time  <= r_highCnt;
                            o_valid      <= 1'b1;
                            if (r_state == ST_LOCKED) begin
                                if (!w_match) begin
                                    o_err      <= 1'b1;
                                    o_locked   <= 1'b0;
                                    r_matchCnt <= '0;
                                    r_state    <= ST_MEASURE;
                                end
                            end else if (!w_match) begin
                                r_matchCnt <= '0;
                            end else if (r_matchCnt == MATCH_LAST) begin
                                r_matchCnt <= MATCH_FULL;
                                o_locked   <= 1'b1;
                                r_state    <= ST_LOCKED;
                            end else begin
                                r_matchCnt <= r_matchCnt + MATCH_ONE;
                            end
                        end else if (w_saturated) begin
                            // No rise for a full counter range: re-acquire from scratch.
                            o_stuck    <= 1'b1;
                            o_locked   <= 1'b0;
                            r_matchCnt <= '0;
                            r_state    <= ST_SYNC;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
